// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and receiver state encoding.
package vga_timing_pkg;

  localparam int unsigned H_TOTAL_DEF          = 800;
  localparam int unsigned V_TOTAL_DEF          = 525;
  localparam int unsigned H_ACTIVE_DEF         = 640;
  localparam int unsigned V_ACTIVE_DEF         = 480;
  localparam int unsigned H_SYNC_TO_ACTIVE_DEF = 144;
  localparam int unsigned V_SYNC_TO_ACTIVE_DEF = 34;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StTrain  = 2'd1,
    StLocked = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Input register for one sync line: polarity folded to active-high, assert-edge pulse.
module sync_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic assert_edge
);

  logic level_q;
  logic prev_q;

  // Sample the pin once and keep one sample of history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      level_q <= sync_in ^ ACTIVE_LOW;
      prev_q  <= level_q;
    end
  end

  assign assert_edge = level_q & ~prev_q;

endmodule

// File: rtl/vga_stream_receiver.sv
// VGA sync-stream receiver: locks to hsync/vsync, regenerates pixel coordinates,
// validates line/frame periods and checksums each active frame.
module vga_stream_receiver
  import vga_timing_pkg::*;
#(
  parameter bit          SYNC_ACTIVE_LOW  = 1'b1,
  parameter int unsigned H_TOTAL          = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL          = V_TOTAL_DEF,
  parameter int unsigned H_ACTIVE         = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE         = V_ACTIVE_DEF,
  parameter int unsigned H_SYNC_TO_ACTIVE = H_SYNC_TO_ACTIVE_DEF,
  parameter int unsigned V_SYNC_TO_ACTIVE = V_SYNC_TO_ACTIVE_DEF,
  parameter int unsigned LOCK_FRAMES      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic        locked,
  output logic        pixel_valid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [2:0]  rgb_q,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        sync_err,
  output logic [7:0]  err_count
);

  localparam logic [10:0] HTotalW   = 11'(H_TOTAL);
  localparam logic [10:0] VTotalW   = 11'(V_TOTAL);
  localparam logic [10:0] WdLast    = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] HStart    = 11'(H_SYNC_TO_ACTIVE);
  localparam logic [10:0] HEnd      = 11'(H_SYNC_TO_ACTIVE + H_ACTIVE);
  localparam logic [10:0] VStart    = 11'(V_SYNC_TO_ACTIVE);
  localparam logic [10:0] VEnd      = 11'(V_SYNC_TO_ACTIVE + V_ACTIVE);
  localparam logic [7:0]  LockGoal  = 8'(LOCK_FRAMES);

  logic h_edge, v_edge;
  logic [2:0] rgb_s_q;

  rx_state_e   state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic [10:0] hcnt_q, hcnt_cur;
  logic [10:0] vcnt_q, vcnt_cur;
  logic        vpend_q, vpend_d;
  logic        h_armed_q, h_armed_d;
  logic        frame_ok_q, frame_ok_d;
  logic        last_q;
  logic [15:0] acc_q, acc_d;

  logic wd_trip, h_edge_eff, boundary, line_bad, frame_good, frame_bad, err_now;
  logic pix_en, valid_d, start_d, last_d;

  sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hsync_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_in     (hsync),
    .assert_edge (h_edge)
  );

  sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vsync_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_in     (vsync),
    .assert_edge (v_edge)
  );

  // Counters and period checks for the sample currently in the input register.
  always_comb begin
    wd_trip    = (hcnt_q == WdLast);
    // A watchdog trip swallows any coincident hsync edge.
    h_edge_eff = h_edge & ~wd_trip;
    boundary   = h_edge_eff & vpend_q;
    hcnt_cur   = (h_edge_eff || wd_trip) ? 11'd0 : hcnt_q + 11'd1;
    vcnt_cur   = h_edge_eff ? (vpend_q ? 11'd0 : vcnt_q + 11'd1) : vcnt_q;
    // vpend set by this sample is consumed by a later hsync edge, not this one.
    vpend_d    = v_edge ? 1'b1 : (h_edge_eff ? 1'b0 : vpend_q);
    line_bad   = h_edge_eff & h_armed_q & (hcnt_q + 11'd1 != HTotalW);
    frame_good = frame_ok_q & ~line_bad & (vcnt_q + 11'd1 == VTotalW);
    frame_bad  = boundary & ~frame_good;
  end

  // Lock state machine: next state, good-frame count, error detection.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_now = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (v_edge) begin
          state_d = StTrain;
          good_d  = 8'd0;
        end
      end
      StTrain: begin
        if (wd_trip) begin
          state_d = StSearch;
        end else if (boundary) begin
          if (!frame_good) begin
            good_d = 8'd0;
          end else if (good_q + 8'd1 >= LockGoal) begin
            state_d = StLocked;
            good_d  = 8'd0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
      end
      StLocked: begin
        if (wd_trip || line_bad || frame_bad) begin
          err_now = 1'b1;
          state_d = StSearch;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // Frame-validity tracking, pixel decode and checksum accumulation.
  always_comb begin
    h_armed_d  = (state_d == StSearch) ? 1'b0 : (h_edge_eff ? 1'b1 : h_armed_q);
    frame_ok_d = frame_ok_q;
    if (state_d == StSearch) begin
      frame_ok_d = 1'b0;
    end else if (boundary) begin
      frame_ok_d = 1'b1;
    end else if (line_bad) begin
      frame_ok_d = 1'b0;
    end
    pix_en  = (state_d == StLocked);
    valid_d = pix_en && (hcnt_cur >= HStart) && (hcnt_cur < HEnd) &&
              (vcnt_cur >= VStart) && (vcnt_cur < VEnd);
    start_d = valid_d && (hcnt_cur == HStart) && (vcnt_cur == VStart);
    last_d  = valid_d && (hcnt_cur == HEnd - 11'd1) && (vcnt_cur == VEnd - 11'd1);
    acc_d   = acc_q;
    if (!pix_en) begin
      acc_d = 16'd0;
    end else if (start_d) begin
      acc_d = {13'd0, rgb_s_q};
    end else if (valid_d) begin
      acc_d = acc_q + {13'd0, rgb_s_q};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_s_q     <= 3'd0;
      state_q     <= StSearch;
      good_q      <= 8'd0;
      hcnt_q      <= 11'd0;
      vcnt_q      <= 11'd0;
      vpend_q     <= 1'b0;
      h_armed_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      last_q      <= 1'b0;
      acc_q       <= 16'd0;
      pixel_valid <= 1'b0;
      x           <= 10'd0;
      y           <= 10'd0;
      rgb_q       <= 3'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_sum   <= 16'd0;
      sync_err    <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      rgb_s_q     <= rgb;
      state_q     <= state_d;
      good_q      <= good_d;
      hcnt_q      <= hcnt_cur;
      vcnt_q      <= vcnt_cur;
      vpend_q     <= vpend_d;
      h_armed_q   <= h_armed_d;
      frame_ok_q  <= frame_ok_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      pixel_valid <= valid_d;
      x           <= valid_d ? 10'(hcnt_cur - HStart) : 10'd0;
      y           <= valid_d ? 10'(vcnt_cur - VStart) : 10'd0;
      rgb_q       <= valid_d ? rgb_s_q : 3'd0;
      frame_start <= start_d;
      // acc_q already holds the last pixel when last_q is set.
      frame_done  <= last_q;
      if (last_q) frame_sum <= acc_q;
      sync_err    <= err_now;
      if (err_now && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign locked = (state_q == StLocked);

endmodule

// File: tb/tb_vga_stream_receiver.sv
// Directed bench for vga_stream_receiver using a reduced 8x6 raster (4x3 active).
module tb_vga_stream_receiver;

  localparam int HT = 8;
  localparam int VT = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsync, vsync;
  logic [2:0]  rgb;
  logic        locked, pixel_valid, frame_start, frame_done, sync_err;
  logic [9:0]  x, y;
  logic [2:0]  rgb_q;
  logic [15:0] frame_sum;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int gh = 0, gv = 0, gen_cnt = 0, mode = 0;
  bit hold_h = 1'b0, short_req = 1'b0;
  int pv_cnt = 0, fd_cnt = 0, se_cnt = 0;

  vga_stream_receiver #(
    .SYNC_ACTIVE_LOW  (1'b1),
    .H_TOTAL          (8),
    .V_TOTAL          (6),
    .H_ACTIVE         (4),
    .V_ACTIVE         (3),
    .H_SYNC_TO_ACTIVE (3),
    .V_SYNC_TO_ACTIVE (1),
    .LOCK_FRAMES      (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .locked      (locked),
    .pixel_valid (pixel_valid),
    .x           (x),
    .y           (y),
    .rgb_q       (rgb_q),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_sum   (frame_sum),
    .sync_err    (sync_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one generator sample (hsync at line start, vsync on line 0), then wait a clock.
  // After this returns, the DUT outputs describe sample gen_cnt-2.
  task automatic step();
    int xx, yy;
    logic act;
    logic [2:0] c;
    act = (gh >= 3) && (gh < 7) && (gv >= 2) && (gv < 5);
    xx = gh - 3;
    yy = gv - 2;
    case (mode)
      1:       c = 3'b001;
      2:       c = (((xx ^ yy) & 1) != 0) ? 3'b001 : 3'b011;
      default: c = 3'b000;
    endcase
    rgb   = act ? c : 3'b111;
    hsync = !((gh < 2) && !hold_h);
    vsync = !(gv == 0);
    if (gh == HT - 1 || (short_req && gh == HT - 2)) begin
      if (gh == HT - 2) short_req = 1'b0;
      gh = 0;
      gv = (gv == VT - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
    gen_cnt++;
    @(negedge clk);
    if (pixel_valid) pv_cnt++;
    if (frame_done) fd_cnt++;
    if (sync_err) se_cnt++;
  endtask

  task automatic run_to(input int n);
    while (gen_cnt < n) step();
  endtask

  task automatic wait_locked(input string tag, input int budget);
    int n = 0;
    while (!locked && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(locked), 64'd1);
  endtask

  task automatic wait_sync_err(input string tag, input int budget);
    int n = 0;
    while (!sync_err && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(sync_err), 64'd1);
  endtask

  // From a freshly reset DUT and generator at (0,0): lock, first pixel, first frame.
  task automatic lock_sequence();
    run_to(105);
    check("locked_before_3rd_frame", 64'(locked), 64'd0);
    run_to(106);
    check("locked_rise", 64'(locked), 64'd1);
    run_to(110);
    pv_cnt = 0;
    fd_cnt = 0;
    run_to(117);
    check("first_frame_start", {61'd0, frame_start, pixel_valid, 1'b1}, 64'd7);
    check("first_pixel_xy", {44'd0, x, y}, 64'd0);
    run_to(136);
    check("no_done_before_last", 64'(fd_cnt), 64'd0);
    run_to(137);
    check("frame_done_pulse", 64'(frame_done), 64'd1);
    check("frame_sum_black", 64'(frame_sum), 64'd0);
    run_to(158);
    check("pixels_per_frame", 64'(pv_cnt), 64'd12);
  endtask

  initial begin
    rst_n = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    rgb   = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {12'd0, locked, pixel_valid, x, y, rgb_q, frame_start, frame_done,
                            frame_sum, sync_err, err_count}, 64'd0);
    rst_n = 1'b1;

    lock_sequence();

    // All active pixels colour 1; blanking carries 3'b111 and must be ignored.
    run_to(144);
    mode = 1;
    run_to(185);
    check("sum_ones_done", 64'(frame_done), 64'd1);
    check("sum_ones", 64'(frame_sum), 64'd12);
    run_to(186);
    check("done_one_cycle", 64'(frame_done), 64'd0);

    // Checkerboard frame.
    run_to(192);
    mode = 2;
    run_to(231);
    check("checker_x2y2", {41'd0, pixel_valid, x, y, rgb_q}, {41'd0, 1'b1, 10'd2, 10'd2, 3'b011});
    run_to(232);
    check("checker_x3y2", {41'd0, pixel_valid, x, y, rgb_q}, {41'd0, 1'b1, 10'd3, 10'd2, 3'b001});
    run_to(233);
    check("checker_sum", 64'(frame_sum), 64'd24);

    // One 7-clock line while locked.
    run_to(240);
    fd_cnt = 0;
    run_to(264);
    short_req = 1'b1;
    se_cnt    = 0;
    run_to(272);
    check("short_line_pre", {62'd0, locked, sync_err}, 64'd2);
    run_to(273);
    check("short_line_err", {52'd0, locked, sync_err, pixel_valid, 1'b0, err_count},
          {52'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1});
    pv_cnt = 0;
    run_to(274);
    check("sync_err_one_cycle", 64'(sync_err), 64'd0);
    run_to(392);
    check("relock_pending", 64'(locked), 64'd0);
    run_to(393);
    check("relock", 64'(locked), 64'd1);
    check("no_pixels_unlocked", 64'(pv_cnt), 64'd0);
    check("no_done_interrupted", 64'(fd_cnt), 64'd0);
    check("single_err_pulse", 64'(se_cnt), 64'd1);

    // hsync held deasserted: watchdog trips at hcnt reaching 2*H_TOTAL.
    run_to(400);
    hold_h = 1'b1;
    run_to(416);
    check("watchdog_pre", {62'd0, locked, sync_err}, 64'd2);
    run_to(417);
    check("watchdog_err", {54'd0, locked, sync_err, err_count}, {54'd0, 1'b0, 1'b1, 8'd2});
    run_to(420);
    hold_h = 1'b0;

    // Drive the error count to saturation.
    se_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      wait_locked("sat_relock", 400);
      short_req = 1'b1;
      wait_sync_err("sat_err", 20);
      if (i == 251) check("err_count_254", 64'(err_count), 64'd254);
    end
    check("err_count_sat", 64'(err_count), 64'd255);
    check("sat_pulses", 64'(se_cnt), 64'd300);

    // Reset in the middle of an active frame.
    wait_locked("pre_reset_lock", 400);
    begin
      int n = 0;
      while (!pixel_valid && n < 100) begin
        step();
        n++;
      end
    end
    check("pre_reset_pixel", 64'(pixel_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", {12'd0, locked, pixel_valid, x, y, rgb_q, frame_start,
                                     frame_done, frame_sum, sync_err, err_count}, 64'd0);
    hsync = 1'b1;
    vsync = 1'b1;
    rgb   = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset_held_no_done", 64'(frame_done), 64'd0);
    rst_n   = 1'b1;
    gh      = 0;
    gv      = 0;
    gen_cnt = 0;
    mode    = 0;
    lock_sequence();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
